// File: rtl/afp3_ram_sdp.sv
// Simple-dual-port block RAM for AFP3 staging buffers: byte-enabled write port, one read port,
// 1/2-cycle read latency, read-during-write collision policy and optional post-reset clear.
module afp3_ram_sdp #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned AW            = 11,
    parameter int unsigned RD_LAT        = 1,
    parameter int unsigned COLL_MODE     = 0,
    parameter int unsigned INIT_ON_RESET = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wren,
    input  logic [AW-1:0]      wrad,
    input  logic [WIDTH/8-1:0] wrbe,
    input  logic [WIDTH-1:0]   data,
    input  logic               rden,
    input  logic [AW-1:0]      rdad,
    output logic [WIDTH-1:0]   q,
    output logic               q_valid,
    output logic               coll,
    output logic               init_busy
);

    localparam int unsigned NB    = WIDTH / 8;
    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     cnt;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              run;
    logic              init_wr;
    logic              user_wr;
    logic              rd_acc;
    logic              coll_now;
    logic [WIDTH-1:0]  wr_mask;
    logic [WIDTH-1:0]  rd_old;
    logic [WIDTH-1:0]  rd_data;

    logic [WIDTH-1:0]  q1;
    logic              v1;
    logic              c1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= (INIT_ON_RESET != 0) ? INIT : RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && cnt == '1) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign run       = (state == RUN);
    assign init_busy = (state == INIT);
    assign init_wr   = reset_n && (state == INIT);
    assign user_wr   = reset_n && run && wren;
    assign rd_acc    = run && rden;

    always_ff @(posedge clk) begin
        if (init_wr) begin
            mem[cnt] <= '0;
        end else if (user_wr) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wrbe[i]) begin
                    mem[wrad][8*i +: 8] <= data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        wr_mask = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            wr_mask[8*i +: 8] = {8{wrbe[i]}};
        end
    end

    // A collision with an all-disabled write leaves the word untouched, so it returns old data in every mode.
    always_comb begin
        rd_old   = mem[rdad];
        coll_now = wren && (rdad == wrad);
        rd_data  = rd_old;
        if (coll_now && wrbe != '0) begin
            case (COLL_MODE)
                1:       rd_data = (rd_old & ~wr_mask) | (data & wr_mask);
                2:       rd_data = rd_old;
                default: rd_data = 'x;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q1 <= '0;
            v1 <= 1'b0;
            c1 <= 1'b0;
        end else begin
            v1 <= rd_acc;
            c1 <= rd_acc && coll_now;
            if (rd_acc) begin
                q1 <= rd_data;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [WIDTH-1:0] q2;
        logic             v2;
        logic             c2;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                q2 <= '0;
                v2 <= 1'b0;
                c2 <= 1'b0;
            end else begin
                v2 <= v1;
                c2 <= c1;
                if (v1) begin
                    q2 <= q1;
                end
            end
        end

        assign q       = q2;
        assign q_valid = v2;
        assign coll    = c2;
    end else begin : g_lat1
        assign q       = q1;
        assign q_valid = v1;
        assign coll    = c1;
    end

endmodule

// File: tb/tb_afp3_ram_sdp.sv
// Bench for afp3_ram_sdp: two instances (1-cycle/write-first, 2-cycle/read-first) share stimulus
// and are checked each cycle against a word-array reference model.
module tb_afp3_ram_sdp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wren;
    logic [3:0]  wrad;
    logic [3:0]  wrbe;
    logic [31:0] data;
    logic        rden;
    logic [3:0]  rdad;

    logic [31:0] qa;
    logic        va;
    logic        ca;
    logic        ba;
    logic [31:0] qb;
    logic        vb;
    logic        cb;
    logic        bb;

    int checks = 0;
    int errors = 0;
    int nva    = 0;
    int nvb    = 0;

    // reference model state
    logic [31:0] mem [16];
    int          busy_left = 0;
    logic [31:0] ea_q = '0;
    logic        ea_v = 1'b0;
    logic        ea_c = 1'b0;
    logic [31:0] eb_q = '0;
    logic        eb_v = 1'b0;
    logic        eb_c = 1'b0;
    logic [31:0] pb_q = '0;
    logic        pb_v = 1'b0;
    logic        pb_c = 1'b0;

    always #5 clk = ~clk;

    afp3_ram_sdp #(.WIDTH(32), .AW(4), .RD_LAT(1), .COLL_MODE(1), .INIT_ON_RESET(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .wren(wren), .wrad(wrad), .wrbe(wrbe), .data(data),
        .rden(rden), .rdad(rdad), .q(qa), .q_valid(va), .coll(ca), .init_busy(ba)
    );

    afp3_ram_sdp #(.WIDTH(32), .AW(4), .RD_LAT(2), .COLL_MODE(2), .INIT_ON_RESET(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .wren(wren), .wrad(wrad), .wrbe(wrbe), .data(data),
        .rden(rden), .rdad(rdad), .q(qb), .q_valid(vb), .coll(cb), .init_busy(bb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rn, input bit w, input logic [3:0] wa, input logic [3:0] be,
                              input logic [31:0] d, input bit r, input logic [3:0] ra);
        bit          acc;
        bit          sc;
        logic [31:0] old;
        logic [31:0] mask;
        logic [31:0] sa;
        if (!rn) begin
            busy_left = 16;
            ea_q = '0; ea_v = 1'b0; ea_c = 1'b0;
            eb_q = '0; eb_v = 1'b0; eb_c = 1'b0;
            pb_q = '0; pb_v = 1'b0; pb_c = 1'b0;
        end else begin
            acc = (busy_left == 0) && r;
            old = mem[ra];
            for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{be[i]}};
            sc = acc && w && (wa == ra);
            sa = sc ? ((old & ~mask) | (d & mask)) : old;
            ea_v = acc;
            ea_c = sc;
            if (acc) ea_q = sa;
            eb_v = pb_v;
            eb_c = pb_c;
            if (pb_v) eb_q = pb_q;
            pb_v = acc;
            pb_c = sc;
            pb_q = old;
            if (busy_left > 0) begin
                mem[16 - busy_left] = '0;
                busy_left--;
            end else if (w) begin
                for (int i = 0; i < 4; i++) if (be[i]) mem[wa][8*i +: 8] = d[8*i +: 8];
            end
        end
    endtask

    task automatic cyc(input bit rn, input bit w, input logic [3:0] wa, input logic [3:0] be,
                       input logic [31:0] d, input bit r, input logic [3:0] ra);
        reset_n = rn; wren = w; wrad = wa; wrbe = be; data = d; rden = r; rdad = ra;
        @(posedge clk);
        model_edge(rn, w, wa, be, d, r, ra);
        #1;
        if (va === 1'b1) nva++;
        if (vb === 1'b1) nvb++;
        chk("a_busy",  {31'b0, ba}, {31'b0, busy_left > 0});
        chk("b_busy",  {31'b0, bb}, {31'b0, busy_left > 0});
        chk("a_valid", {31'b0, va}, {31'b0, ea_v});
        chk("b_valid", {31'b0, vb}, {31'b0, eb_v});
        chk("a_coll",  {31'b0, ca}, {31'b0, ea_c});
        chk("b_coll",  {31'b0, cb}, {31'b0, eb_c});
        chk("a_q", qa, ea_q);
        chk("b_q", qb, eb_q);
    endtask

    task automatic idle();
        cyc(1, 0, 4'd0, 4'd0, 32'd0, 0, 4'd0);
    endtask

    task automatic rnd_busy(input bit rn);
        cyc(rn, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 32'($urandom), 1, 4'($urandom));
    endtask

    initial begin
        // reset with user activity present
        repeat (3) rnd_busy(0);
        chk("rst_q_a", qa, 32'h0);
        chk("rst_q_b", qb, 32'h0);
        chk("rst_busy", {31'b0, ba}, 32'd1);

        // clear phase: busy exactly 16 cycles, user reads/writes ignored
        nva = 0; nvb = 0;
        repeat (16) rnd_busy(1);
        chk("init_done", {31'b0, ba}, 32'd0);
        chk("busy_reads_a", nva, 0);

        nva = 0; nvb = 0;
        for (int a = 0; a < 16; a++) cyc(1, 0, 4'd0, 4'd0, 32'd0, 1, 4'(a));
        idle();
        idle();
        chk("sweep_pulses_a", nva, 16);
        chk("sweep_pulses_b", nvb, 16);

        // byte enables
        cyc(1, 1, 4'd5, 4'hF, 32'hAABBCCDD, 0, 4'd0);
        cyc(1, 1, 4'd5, 4'b0101, 32'h11223344, 0, 4'd0);
        cyc(1, 0, 4'd0, 4'd0, 32'd0, 1, 4'd5);
        chk("be_a", qa, 32'hAA22CC44);
        idle();
        chk("be_b", qb, 32'hAA22CC44);

        // collision on address 7 (still zero from the clear)
        cyc(1, 1, 4'd7, 4'b1100, 32'hFFFF0000, 1, 4'd7);
        chk("coll_q_a", qa, 32'hFFFF0000);
        chk("coll_flag_a", {31'b0, ca}, 32'd1);
        cyc(1, 0, 4'd0, 4'd0, 32'd0, 1, 4'd7);
        chk("coll_q_b", qb, 32'h00000000);
        chk("coll_flag_b", {31'b0, cb}, 32'd1);
        chk("after_coll_a", qa, 32'hFFFF0000);
        idle();
        chk("after_coll_b", qb, 32'hFFFF0000);

        // streaming 0..7 back-to-back, then hold
        nvb = 0;
        for (int a = 0; a < 8; a++) cyc(1, 0, 4'd0, 4'd0, 32'd0, 1, 4'(a));
        repeat (3) idle();
        chk("stream_pulses_b", nvb, 8);

        // random traffic
        repeat (300) cyc(1, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 32'($urandom),
                         1'($urandom_range(0, 1)), 4'($urandom));

        // reset at init count 9
        repeat (2) rnd_busy(0);
        repeat (9) rnd_busy(1);
        rnd_busy(0);
        nva = 0;
        repeat (16) rnd_busy(1);
        chk("reinit_done", {31'b0, ba}, 32'd0);
        chk("reinit_no_reads", nva, 0);
        for (int a = 0; a < 16; a++) cyc(1, 0, 4'd0, 4'd0, 32'd0, 1, 4'(a));
        idle();
        idle();

        // reset right after a read on the 2-cycle instance
        cyc(1, 0, 4'd0, 4'd0, 32'd0, 1, 4'd5);
        nvb = 0;
        cyc(0, 0, 4'd0, 4'd0, 32'd0, 0, 4'd0);
        cyc(0, 0, 4'd0, 4'd0, 32'd0, 0, 4'd0);
        repeat (4) idle();
        chk("midread_no_valid", nvb, 0);
        chk("midread_q_zero", qb, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
